sd_cmd_tx: RTL and testbench

SD host command-line transmitter. Accepts a command index and 32-bit argument over a ready/start handshake and serializes the 48-bit SD command frame MSB-first onto the CMD line: start bit, transmission bit, index, argument, CRC7 and end bit. The CRC7 is computed on the fly. The block then enforces the inter-command NCC gap. It sits between the SD startup/command sequencer (upstream) and the CMD pad tristate (downstream), and all bit timing follows an external SD bit-rate strobe.

---
 rtl/sd_cmd_tx.sv | 157 +++++++++++++++
 tb/tb_sd_cmd_tx.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_tx.sv
// SD host command-line transmitter: serializes the 48-bit command frame
// (start, transmission, index, argument, CRC7, end) on TICK boundaries,
// then holds the line released for GAP_BITS ticks before going idle.
module sd_cmd_tx #(
    parameter int unsigned GAP_BITS = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        TICK,
    input  logic        START,
    input  logic [5:0]  CMD_IDX,
    input  logic [31:0] CMD_ARG,
    output logic        READY,
    output logic        DONE,
    output logic        CMD_O,
    output logic        CMD_OE,
    output logic [6:0]  CRC_O
);

    localparam int unsigned DATA_BITS = 40;
    localparam int unsigned CRC_BITS  = 7;
    localparam int unsigned CNT_W     = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_CRC,
        S_END,
        S_GAP
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [CRC_BITS-1:0]    crc_q,   crc_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    logic                   ready_q, ready_d;
    logic                   done_q,  done_d;
    logic                   cmd_q,   cmd_d;
    logic                   oe_q,    oe_d;
    logic [CRC_BITS-1:0]    crc_o_q, crc_o_d;
    logic                   fb_c;

    // CRC7 feedback for the data bit currently at the head of the shifter
    assign fb_c = shreg_q[DATA_BITS-1] ^ crc_q[CRC_BITS-1];

    // Next-state, shifter, CRC and output computation
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        cmd_d   = cmd_q;
        oe_d    = oe_q;
        crc_o_d = crc_o_q;

        case (state_q)
            S_IDLE: begin
                // Accept only; the first bit waits for the next tick
                if (START) begin
                    shreg_d = {2'b01, CMD_IDX, CMD_ARG};
                    crc_d   = '0;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT, S_DATA: begin
                if (TICK) begin
                    cmd_d   = shreg_q[DATA_BITS-1];
                    oe_d    = 1'b1;
                    shreg_d = {shreg_q[DATA_BITS-2:0], 1'b0};
                    crc_d   = {crc_q[5:3], crc_q[2] ^ fb_c, crc_q[1:0], fb_c};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
                        cnt_d   = '0;
                        state_d = S_CRC;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_CRC: begin
                // CRC is final here; publish it and shift it out MSB-first
                if (TICK) begin
                    cmd_d = crc_q[CRC_BITS-1];
                    crc_d = {crc_q[CRC_BITS-2:0], 1'b0};
                    if (cnt_q == '0) begin
                        crc_o_d = crc_q;
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(CRC_BITS - 1)) begin
                        cnt_d   = '0;
                        state_d = S_END;
                    end
                end
            end
            S_END: begin
                if (TICK) begin
                    cmd_d   = 1'b1;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                // Released line; the first gap tick is the release itself
                if (TICK) begin
                    cmd_d = 1'b1;
                    oe_d  = 1'b0;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(GAP_BITS - 1)) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset releases the pad immediately
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            crc_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            cmd_q   <= 1'b1;
            oe_q    <= 1'b0;
            crc_o_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            cmd_q   <= cmd_d;
            oe_q    <= oe_d;
            crc_o_q <= crc_o_d;
        end
    end

    assign READY  = ready_q;
    assign DONE   = done_q;
    assign CMD_O  = cmd_q;
    assign CMD_OE = oe_q;
    assign CRC_O  = crc_o_q;

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Bench for sd_cmd_tx: two instances (GAP_BITS=8 and GAP_BITS=1) checked
// every cycle against a tick-timeline model, plus literal frame/CRC checks.
module tb_sd_cmd_tx;

    localparam int unsigned G0 = 8;
    localparam int unsigned G1 = 1;

    logic        CLK = 1'b0;
    logic        RST;
    logic        TICK;
    logic        START0, START1;
    logic [5:0]  CMD_IDX;
    logic [31:0] CMD_ARG;

    logic        ready_w [2];
    logic        done_w  [2];
    logic        cmd_w   [2];
    logic        oe_w    [2];
    logic [6:0]  crc_w   [2];

    int vectors     = 0;
    int miscompares = 0;

    sd_cmd_tx #(.GAP_BITS(G0)) u_dut0 (
        .CLK(CLK), .RST(RST), .TICK(TICK), .START(START0),
        .CMD_IDX(CMD_IDX), .CMD_ARG(CMD_ARG),
        .READY(ready_w[0]), .DONE(done_w[0]), .CMD_O(cmd_w[0]),
        .CMD_OE(oe_w[0]), .CRC_O(crc_w[0])
    );

    sd_cmd_tx #(.GAP_BITS(G1)) u_dut1 (
        .CLK(CLK), .RST(RST), .TICK(TICK), .START(START1),
        .CMD_IDX(CMD_IDX), .CMD_ARG(CMD_ARG),
        .READY(ready_w[1]), .DONE(done_w[1]), .CMD_O(cmd_w[1]),
        .CMD_OE(oe_w[1]), .CRC_O(crc_w[1])
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int inst,
                         input logic [47:0] act, input logic [47:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h at %0t", name, inst, act, exp, $time);
        end
    endtask

    task automatic fail(input string name, input int inst);
        vectors++;
        miscompares++;
        $display("FAIL %s[%0d]: wait bound expired at %0t", name, inst, $time);
    endtask

    // Full 48-bit frame straight from the frame layout and CRC7 rule
    function automatic logic [47:0] build(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] d;
        logic [6:0]  c;
        logic        fb;
        d = {2'b01, idx, arg};
        c = '0;
        for (int k = 39; k >= 0; k--) begin
            fb = d[k] ^ c[6];
            c  = {c[5:0], fb} ^ {3'b000, fb, 3'b000};
        end
        return {d, c, 1'b1};
    endfunction

    function automatic int gap_of(input int i);
        return (i == 0) ? int'(G0) : int'(G1);
    endfunction

    function automatic logic start_of(input int i);
        return (i == 0) ? START0 : START1;
    endfunction

    // Tick-timeline model: position n counts ticks since accept
    bit          m_busy  [2];
    int          m_n     [2];
    int          m_acc   [2];
    logic [47:0] m_frame [2];
    logic        m_ready [2];
    logic        m_done  [2];
    logic        m_cmd   [2];
    logic        m_oe    [2];
    logic [6:0]  m_crc   [2];

    always @(posedge CLK or posedge RST) begin
        for (int i = 0; i < 2; i++) begin
            if (RST) begin
                m_busy[i]  = 1'b0;
                m_n[i]     = 0;
                m_ready[i] = 1'b1;
                m_done[i]  = 1'b0;
                m_cmd[i]   = 1'b1;
                m_oe[i]    = 1'b0;
                m_crc[i]   = '0;
            end else begin
                m_done[i] = 1'b0;
                if (m_busy[i]) begin
                    if (TICK) begin
                        m_n[i]++;
                        if (m_n[i] <= 48) begin
                            m_cmd[i] = m_frame[i][48 - m_n[i]];
                            m_oe[i]  = 1'b1;
                        end else begin
                            m_cmd[i] = 1'b1;
                            m_oe[i]  = 1'b0;
                        end
                        if (m_n[i] == 41) m_crc[i] = m_frame[i][7:1];
                        if (m_n[i] == 48 + gap_of(i)) begin
                            m_done[i]  = 1'b1;
                            m_ready[i] = 1'b1;
                            m_busy[i]  = 1'b0;
                        end
                    end
                end else if (start_of(i)) begin
                    m_frame[i] = build(CMD_IDX, CMD_ARG);
                    m_busy[i]  = 1'b1;
                    m_n[i]     = 0;
                    m_ready[i] = 1'b0;
                    m_acc[i]++;
                end
            end
        end
    end

    int   cyc       = 0;
    logic last_tick = 1'b0;

    always @(posedge CLK) begin
        cyc       <= cyc + 1;
        last_tick <= TICK;
    end

    // Hand-written expected frames, consumed in order at each DONE
    logic [47:0] exp_frame [2][16];
    int          exp_wr    [2];
    int          exp_rd    [2];
    logic [47:0] cap       [2];
    int          capn      [2];
    int          gapn      [2];
    int          ndone     [2];
    int          done_cyc  [2];

    // Per-cycle compare against the model plus per-frame capture checks
    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            check("READY",  i, 48'(ready_w[i]), 48'(m_ready[i]));
            check("DONE",   i, 48'(done_w[i]),  48'(m_done[i]));
            check("CMD_O",  i, 48'(cmd_w[i]),   48'(m_cmd[i]));
            check("CMD_OE", i, 48'(oe_w[i]),    48'(m_oe[i]));
            check("CRC_O",  i, 48'(crc_w[i]),   48'(m_crc[i]));
            if (RST) begin
                cap[i]  = '0;
                capn[i] = 0;
                gapn[i] = 0;
            end else begin
                if (last_tick && oe_w[i]) begin
                    cap[i] = {cap[i][46:0], cmd_w[i]};
                    capn[i]++;
                end
                if (last_tick && !oe_w[i] && capn[i] == 48) gapn[i]++;
                if (done_w[i]) begin
                    ndone[i]++;
                    done_cyc[i] = cyc;
                    if (exp_rd[i] >= exp_wr[i]) begin
                        check("unexpected_DONE", i, 48'(done_w[i]), 48'(0));
                    end else begin
                        check("frame",     i, cap[i], exp_frame[i][exp_rd[i]]);
                        check("crc_done",  i, 48'(crc_w[i]), 48'(exp_frame[i][exp_rd[i]][7:1]));
                        check("oe_ticks",  i, 48'(capn[i]), 48'(48));
                        check("gap_ticks", i, 48'(gapn[i]), 48'(gap_of(i)));
                        exp_rd[i]++;
                    end
                    cap[i]  = '0;
                    capn[i] = 0;
                    gapn[i] = 0;
                end
            end
        end
    end

    // TICK strobe: one cycle in every tick_div, or continuous when tick_div<=1
    int tick_div = 4;
    int tdc      = 0;

    initial begin
        TICK = 1'b0;
        forever begin
            @(negedge CLK);
            tdc++;
            TICK = (tick_div <= 1) ? 1'b1 : ((tdc % tick_div) == 0);
        end
    end

    task automatic set_start(input int inst, input logic v);
        if (inst == 0) START0 = v;
        else           START1 = v;
    endtask

    // Raise START until the model sees an accept; optionally record a frame
    task automatic send(input int inst, input logic [5:0] idx, input logic [31:0] arg,
                        input logic [47:0] lit, input bit last, input bit push);
        int a0;
        int n;
        a0 = m_acc[inst];
        n  = 0;
        CMD_IDX = idx;
        CMD_ARG = arg;
        set_start(inst, 1'b1);
        while (m_acc[inst] == a0 && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        if (m_acc[inst] == a0) fail("accept_timeout", inst);
        if (push) begin
            exp_frame[inst][exp_wr[inst]] = lit;
            exp_wr[inst]++;
        end
        if (last) set_start(inst, 1'b0);
    endtask

    task automatic wait_idle(input int inst);
        int n = 0;
        while (!m_ready[inst] && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        if (!m_ready[inst]) fail("idle_timeout", inst);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog[0]: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cyc;
        int n;
        RST     = 1'b1;
        START0  = 1'b0;
        START1  = 1'b0;
        CMD_IDX = '0;
        CMD_ARG = '0;

        // Model pins against known SD frames
        check("model_cmd0",  0, build(6'd0,  32'h0),      48'h400000000095);
        check("model_cmd8",  0, build(6'd8,  32'h1AA),    48'h48000001AA87);
        check("model_cmd55", 0, build(6'd55, 32'h0),      48'h770000000065);
        check("model_cmd17", 0, build(6'd17, 32'h0),      48'h510000000055);

        // Reset values
        repeat (3) @(negedge CLK);
        check("rst_READY",  0, 48'(ready_w[0]), 48'(1));
        check("rst_DONE",   0, 48'(done_w[0]),  48'(0));
        check("rst_CMD_O",  0, 48'(cmd_w[0]),   48'(1));
        check("rst_CMD_OE", 0, 48'(oe_w[0]),    48'(0));
        check("rst_CRC_O",  0, 48'(crc_w[0]),   48'(0));
        #1 RST = 1'b0;

        // CMD0, TICK every 4 clocks
        send(0, 6'd0, 32'h0, 48'h400000000095, 1'b1, 1'b1);
        wait_idle(0);
        check("crc_cmd0", 0, 48'(crc_w[0]), 48'(7'h4A));

        // Back-to-back CMD8/CMD55/CMD17 with START held high
        send(0, 6'd8,  32'h1AA, 48'h48000001AA87, 1'b0, 1'b1);
        send(0, 6'd55, 32'h0,   48'h770000000065, 1'b0, 1'b1);
        send(0, 6'd17, 32'h0,   48'h510000000055, 1'b1, 1'b1);
        wait_idle(0);
        check("crc_cmd17", 0, 48'(crc_w[0]), 48'(7'h2A));

        // START mid-frame with different operands is ignored
        tick_div = 3;
        send(0, 6'd17, 32'h0, 48'h510000000055, 1'b1, 1'b1);
        repeat (40) @(negedge CLK);
        CMD_IDX = 6'd5;
        CMD_ARG = 32'hDEADBEEF;
        START0  = 1'b1;
        @(negedge CLK);
        START0  = 1'b0;
        wait_idle(0);

        // Continuous TICK, START coincident with TICK in idle
        tick_div = 1;
        repeat (2) @(negedge CLK);
        send(0, 6'd55, 32'h0, 48'h770000000065, 1'b1, 1'b1);
        acc_cyc = cyc;
        check("e0_CMD_OE", 0, 48'(oe_w[0]),    48'(0));
        check("e0_READY",  0, 48'(ready_w[0]), 48'(0));
        @(negedge CLK);
        check("t1_CMD_OE", 0, 48'(oe_w[0]),    48'(1));
        check("t1_CMD_O",  0, 48'(cmd_w[0]),   48'(0));
        wait_idle(0);
        @(negedge CLK);
        check("done_latency", 0, 48'(done_cyc[0] - acc_cyc), 48'(56));
        check("crc_cmd55", 0, 48'(crc_w[0]), 48'(7'h32));

        // Reset at tick 20 of a frame, then a clean CMD0
        tick_div = 2;
        repeat (2) @(negedge CLK);
        send(0, 6'd8, 32'h1AA, 48'h48000001AA87, 1'b1, 1'b0);
        n = 0;
        while (m_n[0] < 20 && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        if (m_n[0] < 20) fail("tick20_timeout", 0);
        #1 RST = 1'b1;
        #1;
        check("midrst_CMD_OE", 0, 48'(oe_w[0]),    48'(0));
        check("midrst_CMD_O",  0, 48'(cmd_w[0]),   48'(1));
        check("midrst_READY",  0, 48'(ready_w[0]), 48'(1));
        check("midrst_DONE",   0, 48'(done_w[0]),  48'(0));
        @(negedge CLK);
        #1 RST = 1'b0;
        send(0, 6'd0, 32'h0, 48'h400000000095, 1'b1, 1'b1);
        wait_idle(0);
        check("crc_after_rst", 0, 48'(crc_w[0]), 48'(7'h4A));

        // GAP_BITS=1 instance, back-to-back CMD0 then CMD8
        tick_div = 4;
        repeat (2) @(negedge CLK);
        send(1, 6'd0, 32'h0,   48'h400000000095, 1'b0, 1'b1);
        send(1, 6'd8, 32'h1AA, 48'h48000001AA87, 1'b1, 1'b1);
        wait_idle(1);
        check("crc_gap1", 1, 48'(crc_w[1]), 48'(7'h43));

        repeat (4) @(negedge CLK);
        check("done_count", 0, 48'(ndone[0]), 48'(exp_wr[0]));
        check("done_count", 1, 48'(ndone[1]), 48'(exp_wr[1]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
